// File: rtl/display_scan_ctrl.sv
// Two-digit 7-segment scan controller: time-multiplexes tens/units digits on a
// shared segment bus, with blanking gaps and a value handshake taken only in gaps.
module display_scan_ctrl #(
    parameter int unsigned SCAN_DIV   = 4,
    parameter bit          LEAD_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_val,
    output logic       in_ready,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic [3:0] cur_val
);

    typedef enum logic [1:0] {
        TENS  = 2'd0,
        GAP0  = 2'd1,
        UNITS = 2'd2,
        GAP1  = 2'd3
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(SCAN_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] cur_q, cur_d;

    logic       is_ten;
    logic [3:0] tens_digit;
    logic [3:0] units_digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        s = '0;
        case (d)
            4'd0: s = 7'b1111110;
            4'd1: s = 7'b0110000;
            4'd2: s = 7'b1101101;
            4'd3: s = 7'b1111001;
            4'd4: s = 7'b0110011;
            4'd5: s = 7'b1011011;
            4'd6: s = 7'b1011111;
            4'd7: s = 7'b1110000;
            4'd8: s = 7'b1111111;
            4'd9: s = 7'b1110011;
            default: s = '0;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= GAP1;
            cnt_q   <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            TENS: begin
                if (cnt_q == DWELL_LAST) state_d = GAP0;
                else                     cnt_d   = cnt_q + 8'd1;
            end
            GAP0: state_d = UNITS;
            UNITS: begin
                if (cnt_q == DWELL_LAST) state_d = GAP1;
                else                     cnt_d   = cnt_q + 8'd1;
            end
            GAP1: state_d = TENS;
            default: state_d = GAP1;
        endcase
    end

    // Accepting only in gaps keeps the displayed value stable while a digit is lit.
    assign in_ready = (state_q == GAP0) || (state_q == GAP1);
    assign cur_d    = (in_valid && in_ready) ? in_val : cur_q;
    assign cur_val  = cur_q;

    assign is_ten      = (cur_q >= 4'd10);
    assign tens_digit  = {3'b000, is_ten};
    assign units_digit = is_ten ? (cur_q - 4'd10) : cur_q;

    always_comb begin
        seg    = '0;
        dig_en = '0;
        case (state_q)
            TENS: begin
                if (!(LEAD_BLANK && !is_ten)) begin
                    dig_en = 2'b10;
                    seg    = decode(tens_digit);
                end
            end
            UNITS: begin
                dig_en = 2'b01;
                seg    = decode(units_digit);
            end
            default: begin
                dig_en = '0;
                seg    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed scoreboard bench for display_scan_ctrl: default, no-blanking and
// SCAN_DIV=1 instances run in lockstep from a shared clock and reset.
module tb_display_scan_ctrl;

    localparam logic [6:0] OFF = 7'b0000000;
    localparam logic [6:0] S0  = 7'b1111110;
    localparam logic [6:0] S1  = 7'b0110000;
    localparam logic [6:0] S3  = 7'b1111001;
    localparam logic [6:0] S5  = 7'b1011011;
    localparam logic [6:0] S9  = 7'b1110011;

    typedef struct {
        string       tag;
        int unsigned dut;
        logic [1:0]  dig;
        logic [6:0]  seg;
        logic        rdy;
        logic [3:0]  cur;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v, v2;
    logic [3:0] val, val2;

    logic       rdy0, rdy1, rdy2;
    logic [6:0] seg0, seg1, seg2;
    logic [1:0] dig0, dig1, dig2;
    logic [3:0] cur0, cur1, cur2;

    exp_t        sb[$];
    logic [6:0]  segtab[10];
    int unsigned pass_cnt  = 0;
    int unsigned fail_cnt  = 0;
    int unsigned total_cnt = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(.SCAN_DIV(4), .LEAD_BLANK(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v), .in_val(val), .in_ready(rdy0),
        .seg(seg0), .dig_en(dig0), .cur_val(cur0));

    display_scan_ctrl #(.SCAN_DIV(4), .LEAD_BLANK(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v), .in_val(val), .in_ready(rdy1),
        .seg(seg1), .dig_en(dig1), .cur_val(cur1));

    display_scan_ctrl #(.SCAN_DIV(1), .LEAD_BLANK(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_val(val2), .in_ready(rdy2),
        .seg(seg2), .dig_en(dig2), .cur_val(cur2));

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int unsigned dut, input logic [1:0] dig,
                        input logic [6:0] sg, input logic rdy, input logic [3:0] cur);
        exp_t e;
        e.tag = tag; e.dut = dut; e.dig = dig; e.seg = sg; e.rdy = rdy; e.cur = cur;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t       e;
        logic [1:0] d;
        logic [6:0] s;
        logic       r;
        logic [3:0] c;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin d = dig0; s = seg0; r = rdy0; c = cur0; end
                1:       begin d = dig1; s = seg1; r = rdy1; c = cur1; end
                default: begin d = dig2; s = seg2; r = rdy2; c = cur2; end
            endcase
            chk({e.tag, ".dig"}, {5'b0, d}, {5'b0, e.dig});
            chk({e.tag, ".seg"}, s, e.seg);
            chk({e.tag, ".rdy"}, {6'b0, r}, {6'b0, e.rdy});
            chk({e.tag, ".cur"}, {3'b0, c}, {3'b0, e.cur});
            if (e.dut == 2) chk({e.tag, ".not11"}, {6'b0, (d == 2'b11)}, 7'd0);
        end
    endtask

    task automatic push01(input string tag, input logic [1:0] d0, input logic [6:0] s0,
                          input logic [1:0] d1, input logic [6:0] s1,
                          input logic rdy, input logic [3:0] cur);
        push({tag, "/u0"}, 0, d0, s0, rdy, cur);
        push({tag, "/u1"}, 1, d1, s1, rdy, cur);
    endtask

    task automatic run(input int unsigned n, input string tag,
                       input logic [1:0] d0, input logic [6:0] s0,
                       input logic [1:0] d1, input logic [6:0] s1,
                       input logic rdy, input logic [3:0] cur);
        for (int unsigned i = 0; i < n; i++) begin
            push01(tag, d0, s0, d1, s1, rdy, cur);
            tick();
        end
    endtask

    initial begin
        int unsigned p;
        int unsigned acc;
        logic [3:0]  ecur;
        logic [1:0]  ed;
        logic [6:0]  es;
        logic        gap;

        segtab[0] = 7'b1111110; segtab[1] = 7'b0110000; segtab[2] = 7'b1101101;
        segtab[3] = 7'b1111001; segtab[4] = 7'b0110011; segtab[5] = 7'b1011011;
        segtab[6] = 7'b1011111; segtab[7] = 7'b1110000; segtab[8] = 7'b1111111;
        segtab[9] = 7'b1110011;

        rst_n = 1'b0; v = 1'b0; val = '0; v2 = 1'b0; val2 = '0;
        tick();
        push01("rst", 2'b00, OFF, 2'b00, OFF, 1'b1, 4'd0);
        push("rst/u2", 2, 2'b00, OFF, 1'b1, 4'd0);
        tick();

        // scan timing after release
        rst_n = 1'b1;
        run(4, "A.tens",  2'b00, OFF, 2'b10, S0,  1'b0, 4'd0);
        run(1, "A.gap0",  2'b00, OFF, 2'b00, OFF, 1'b1, 4'd0);
        run(4, "A.units", 2'b01, S0,  2'b01, S0,  1'b0, 4'd0);
        run(1, "A.gap1",  2'b00, OFF, 2'b00, OFF, 1'b1, 4'd0);
        run(4, "A.tens2", 2'b00, OFF, 2'b10, S0,  1'b0, 4'd0);
        run(1, "A.gap0b", 2'b00, OFF, 2'b00, OFF, 1'b1, 4'd0);

        // offer 13 during UNITS; must wait for GAP1
        run(1, "B.units", 2'b01, S0, 2'b01, S0, 1'b0, 4'd0);
        v = 1'b1; val = 4'd13;
        run(3, "B.wait",  2'b01, S0,  2'b01, S0,  1'b0, 4'd0);
        run(1, "B.gap1",  2'b00, OFF, 2'b00, OFF, 1'b1, 4'd0);
        run(1, "B.tens",  2'b10, S1,  2'b10, S1,  1'b0, 4'd13);
        v = 1'b0;
        run(3, "B.tens",  2'b10, S1,  2'b10, S1,  1'b0, 4'd13);
        run(1, "B.gap0",  2'b00, OFF, 2'b00, OFF, 1'b1, 4'd13);
        run(4, "B.units", 2'b01, S3,  2'b01, S3,  1'b0, 4'd13);
        run(1, "B.gap1b", 2'b00, OFF, 2'b00, OFF, 1'b1, 4'd13);

        // value 9: blanked tens only with LEAD_BLANK=1
        v = 1'b1; val = 4'd9;
        run(1, "C.tens",  2'b00, OFF, 2'b10, S0,  1'b0, 4'd9);
        v = 1'b0;
        run(3, "C.tens",  2'b00, OFF, 2'b10, S0,  1'b0, 4'd9);
        run(1, "C.gap0",  2'b00, OFF, 2'b00, OFF, 1'b1, 4'd9);
        run(4, "C.units", 2'b01, S9,  2'b01, S9,  1'b0, 4'd9);
        run(1, "C.gap1",  2'b00, OFF, 2'b00, OFF, 1'b1, 4'd9);

        // boundaries 10 and 15
        v = 1'b1; val = 4'd10;
        run(1, "D.tens10",  2'b10, S1,  2'b10, S1,  1'b0, 4'd10);
        v = 1'b0;
        run(3, "D.tens10",  2'b10, S1,  2'b10, S1,  1'b0, 4'd10);
        run(1, "D.gap0",    2'b00, OFF, 2'b00, OFF, 1'b1, 4'd10);
        run(4, "D.units10", 2'b01, S0,  2'b01, S0,  1'b0, 4'd10);
        run(1, "D.gap1",    2'b00, OFF, 2'b00, OFF, 1'b1, 4'd10);
        v = 1'b1; val = 4'd15;
        run(1, "D.tens15",  2'b10, S1,  2'b10, S1,  1'b0, 4'd15);
        v = 1'b0;
        run(3, "D.tens15",  2'b10, S1,  2'b10, S1,  1'b0, 4'd15);
        run(1, "D.gap0b",   2'b00, OFF, 2'b00, OFF, 1'b1, 4'd15);
        run(1, "D.units15", 2'b01, S5,  2'b01, S5,  1'b0, 4'd15);

        // reset during UNITS with a pending offer
        v = 1'b1; val = 4'd7; rst_n = 1'b0;
        run(1, "E.rst", 2'b00, OFF, 2'b00, OFF, 1'b1, 4'd0);
        rst_n = 1'b1; v = 1'b0;
        push01("E.tens", 2'b00, OFF, 2'b10, S0, 1'b0, 4'd0);

        // SCAN_DIV=1 stress: in_valid held high, value stepping per acceptance
        v2 = 1'b1; val2 = 4'd1;
        p = 0; ecur = 4'd0; acc = 0;
        for (int unsigned k = 0; k < 24; k++) begin
            gap = (p == 0) || (p == 2);
            if (gap) begin
                ecur = val2;
                acc++;
            end
            p = (p + 1) % 4;
            ed = 2'b00; es = OFF;
            if (p == 1 && ecur >= 4'd10) begin
                ed = 2'b10; es = S1;
            end else if (p == 3) begin
                ed = 2'b01;
                es = segtab[(ecur >= 4'd10) ? ecur - 4'd10 : ecur];
            end
            push($sformatf("F.%0d", k), 2, ed, es, (p == 0) || (p == 2), ecur);
            tick();
            if (gap) val2 = val2 + 4'd1;
        end
        v2 = 1'b0;
        chk("F.acc", 7'(val2 - 4'd1), 7'(acc));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 4, meaning the number of clock cycles each digit is driven per scan (legal range 1..255).
REQ-002 SHALL provide parameter LEAD_BLANK, default 1, meaning that when set, the tens digit is suppressed for values below 10.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL provide port in_valid, input, 1 bit: the requester offers a new value on in_val.
REQ-006 SHALL provide port in_val, input, 4 bits: the binary value 0..15 to display.
REQ-007 SHALL provide port in_ready, output, 1 bit: the block accepts in_val this cycle.
REQ-008 SHALL provide port seg, output, 7 bits: the shared segment bus, bit6=a through bit0=g, active high.
REQ-009 SHALL provide port dig_en, output, 2 bits: one-hot digit enable, bit1=tens and bit0=units; 00 means no digit is enabled.
REQ-010 SHALL provide port cur_val, output, 4 bits: the currently latched display value.

Function
REQ-011 SHALL share the single seg bus between the tens and units digits by time-multiplexing them under a registered four-state FSM: TENS, GAP0, UNITS, GAP1.
REQ-012 SHALL hold TENS and UNITS for exactly SCAN_DIV cycles each and GAP0 and GAP1 for exactly 1 cycle each, giving a scan period of 2*SCAN_DIV+2 cycles.
REQ-013 SHALL sequence the states TENS->GAP0->UNITS->GAP1->TENS, advancing when the dwell counter reaches SCAN_DIV-1 in the digit states and unconditionally in the gap states.
REQ-014 SHALL reset the dwell counter to 0 on every state transition; the counter shall never exceed SCAN_DIV-1.
REQ-015 SHALL split cur_val into tens = (cur_val>=10) and units = cur_val-10*tens, each 4 bits wide.
REQ-016 SHALL decode digits onto seg as: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011.
REQ-017 SHALL, in TENS, drive dig_en=10 with seg equal to the tens decode.
REQ-018 SHALL, in TENS with LEAD_BLANK=1 and cur_val<10, drive dig_en=00 and seg=0000000 for the full dwell time.
REQ-019 SHALL, in UNITS, drive dig_en=01 with seg equal to the units decode.
REQ-020 SHALL, in GAP0 and GAP1, drive dig_en=00 and seg=0000000 to prevent ghosting.
REQ-021 SHALL derive seg and dig_en solely from the registered state and cur_val, so there is no combinational path from in_val or in_valid.
REQ-022 SHALL assert in_ready only in GAP0 and GAP1, so cur_val never changes while a digit is lit.
REQ-023 SHALL latch in_val into cur_val on a clock edge where in_valid=1 and in_ready=1; the new value is visible from the next cycle, which is the following digit state.
REQ-024 SHALL allow in_valid to remain high across digit states with in_val held stable, with the transfer completing at the next gap; in_valid while in_ready=0 shall have no effect.
REQ-025 SHALL accept at most one value per gap cycle; back-to-back offers are accepted at successive gaps, one per half-scan.
REQ-026 SHALL NOT use SCAN_DIV=1 as a special case: the FSM then alternates 1-cycle digit and gap states.

Reset
REQ-027 SHALL, when rst_n=0 at a clock edge, set state=GAP1, dwell counter=0 and cur_val=0000, overriding any simultaneous handshake.
REQ-028 SHALL, while in reset and in the first cycle after rst_n rises, present dig_en=00, seg=0000000 and in_ready=1 as consequences of state GAP1.
REQ-029 SHALL make the first digit shown after reset release TENS, entered one cycle after release.
REQ-030 SHALL, on a reset asserted mid-scan, return to GAP1 on the same edge, discard any pending transfer and restore cur_val to 0.

Verification
REQ-031 SHALL be covered by a scan-timing scenario: SCAN_DIV=4, release reset with in_valid=0 -> GAP1 for 1 cycle, TENS blanked (dig_en=00) for 4 cycles, GAP0 for 1, dig_en=01 with seg=1111110 for 4, and a period of 10.
REQ-032 SHALL be covered by a handshake-and-decode scenario: offer in_val=13 during UNITS -> in_ready=0 until GAP1, transfer accepted at GAP1, then TENS shows dig_en=10 with seg=0110000 and UNITS shows seg=1111001.
REQ-033 SHALL be covered by a blanking scenario: cur_val=9 with LEAD_BLANK=1 -> TENS gives dig_en=00; the same with LEAD_BLANK=0 -> dig_en=10 and seg=1111110.
REQ-034 SHALL be covered by a boundary scenario: cur_val=10 -> tens segments 0110000 and units segments 1111110; cur_val=15 -> units segments 1011011.
REQ-035 SHALL be covered by a mid-operation reset scenario: assert rst_n=0 during UNITS with in_valid=1 -> the next cycle shows GAP1, cur_val=0 and dig_en=00, and the offered value is not latched.
REQ-036 SHALL be covered by a stress scenario: SCAN_DIV=1 with in_valid held high and in_val incrementing -> exactly one acceptance per gap, and dig_en is never 11.
